// File: rtl/posit_normalizer.sv
// posit_normalizer
// ----------------
// Multi-cycle normalization stage placed directly in front of the posit
// packer. It takes an unnormalized magnitude (sign, signed scale, wide
// mantissa), normalizes it by one bit position per clock, then splits the
// scale into regime (k) and exponent and extracts the fraction. The regime is
// saturated to maxpos/minpos so the outputs can feed the packer directly.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   in_valid        operand valid (accepted only while in_ready is high)
//   in_ready        high only in IDLE and while out of reset
//   in_sign         operand sign, passed through to out_sign
//   in_scale        signed scale; value = in_mant * 2^(in_scale-(MW-2))
//   in_mant         unsigned mantissa; hidden bit at MW-2, MW-1 is overflow
//   out_valid       result valid (held until out_ready)
//   out_ready       consumer accepts the result
//   out_sign        registered operand sign
//   out_zero        operand mantissa was zero
//   out_seed        signed regime value k (N bits)
//   out_exp         exponent field (ES bits)
//   out_frac        fraction bits below the hidden bit, MSB-aligned (N bits)
//   out_sticky      OR of all mantissa bits discarded below out_frac

`timescale 1ns/1ps

module posit_normalizer #(
    parameter int N  = 16,
    parameter int ES = 3,
    parameter int MW = 32,
    parameter int SW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [SW-1:0] in_scale,
    input  logic [MW-1:0] in_mant,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic          out_zero,
    output logic [N-1:0]  out_seed,
    output logic [ES-1:0] out_exp,
    output logic [N-1:0]  out_frac,
    output logic          out_sticky
);

    // Two guard bits on the internal scale: at most MW-2 left shifts or one
    // right shift are applied, which can never wrap this register.
    localparam int KW = SW + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Largest regime magnitude the packer can represent (maxpos/minpos).
    localparam logic signed [KW-1:0] K_MAX = KW'(N - 2);
    localparam logic signed [KW-1:0] K_MIN = -K_MAX;

    logic [1:0]           state;
    logic signed [KW-1:0] scale_r;
    logic [MW-1:0]        mant_r;
    logic                 sticky_r;

    logic signed [KW-1:0] k_val;
    logic [ES-1:0]        e_val;
    logic [N-1:0]         frac_val;
    logic                 sticky_val;

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);

    // Field split of the current working value; only consumed on the edge
    // where the mantissa is already normalized.
    always_comb begin
        k_val      = scale_r >>> ES;
        e_val      = scale_r[ES-1:0];
        frac_val   = mant_r[MW-3 -: N];
        sticky_val = sticky_r | (|mant_r[MW-3-N:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            scale_r    <= '0;
            mant_r     <= '0;
            sticky_r   <= 1'b0;
            out_sign   <= 1'b0;
            out_zero   <= 1'b0;
            out_seed   <= '0;
            out_exp    <= '0;
            out_frac   <= '0;
            out_sticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_sign <= in_sign;
                        scale_r  <= {{2{in_scale[SW-1]}}, in_scale};
                        mant_r   <= in_mant;
                        sticky_r <= 1'b0;
                        if (in_mant == '0) begin
                            out_zero   <= 1'b1;
                            out_seed   <= '0;
                            out_exp    <= '0;
                            out_frac   <= '0;
                            out_sticky <= 1'b0;
                            state      <= DONE;
                        end else begin
                            out_zero <= 1'b0;
                            state    <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    // Overflow has priority: a set top bit must come down
                    // before we look for the hidden bit.
                    if (mant_r[MW-1]) begin
                        mant_r   <= mant_r >> 1;
                        sticky_r <= sticky_r | mant_r[0];
                        scale_r  <= scale_r + KW'(1);
                    end else if (!mant_r[MW-2]) begin
                        mant_r  <= mant_r << 1;
                        scale_r <= scale_r - KW'(1);
                    end else begin
                        // Saturation drops exp/frac/sticky entirely so the
                        // packer produces exactly maxpos or minpos, never zero.
                        if (k_val > K_MAX) begin
                            out_seed   <= N'(K_MAX);
                            out_exp    <= '0;
                            out_frac   <= '0;
                            out_sticky <= 1'b0;
                        end else if (k_val < K_MIN) begin
                            out_seed   <= N'(K_MIN);
                            out_exp    <= '0;
                            out_frac   <= '0;
                            out_sticky <= 1'b0;
                        end else begin
                            out_seed   <= N'(k_val);
                            out_exp    <= e_val;
                            out_frac   <= frac_val;
                            out_sticky <= sticky_val;
                        end
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/posit_normalizer.md
Name: posit_normalizer

Overview:
- Multi-cycle normalization stage that sits directly upstream of packer.
- Accepts an unnormalized magnitude (sign, signed scale, wide mantissa) from the arithmetic datapath.
- Normalizes it one bit-shift per cycle, then splits the scale into regime seed and exponent and extracts the fraction.
- Saturates to the maxpos/minpos regime, so the seed/exp/frac outputs wire directly into packer.

Parameters:
N, 16, posit width; also the width of out_seed and out_frac.
ES, 3, exponent field width.
MW, 32, input mantissa width; hidden bit nominal at MW-2, bit MW-1 is overflow.
SW, 12, input scale width (signed).

Ports:
clk  input  1  clock.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  input operand valid.
in_ready  output  1  block can accept an operand (high only in IDLE).
in_sign  input  1  operand sign; passed through unchanged.
in_scale  input  SW  signed power-of-two scale; value = in_mant * 2^(in_scale-(MW-2)).
in_mant  input  MW  unsigned unnormalized mantissa.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_sign  output  1  registered in_sign.
out_zero  output  1  operand was zero.
out_seed  output  N  signed regime value k, fed to packer seed.
out_exp  output  ES  exponent, fed to packer exp.
out_frac  output  N  fraction bits below hidden bit, MSB-aligned, fed to packer frac.
out_sticky  output  1  OR of all mantissa bits discarded below out_frac.

Behaviour:
- Clocking/reset: one clock. Reset is synchronous and active-low; ports are clk and rst_n.
- Reset: state IDLE. out_valid, out_sign, out_zero, out_seed, out_exp, out_frac and out_sticky are all 0. in_ready is 0 while rst_n is low.
- Reset mid-operation: any edge with rst_n low aborts SHIFT or DONE and returns to IDLE. No output pulse follows.
- State IDLE: in_ready=1.
  - On in_valid at an edge, capture sign, scale and mantissa. Scale is sign-extended into an internal register of SW+2 bits so it cannot wrap.
  - If in_mant==0: go to DONE with out_zero=1 and seed/exp/frac/sticky = 0.
  - Otherwise go to SHIFT with sticky cleared.
- State SHIFT: one action per edge, evaluated in this priority order.
  - mant[MW-1]=1: shift right 1, sticky |= mant[0], scale+1.
  - mant[MW-2]=0: shift left 1, scale-1.
  - Otherwise normalized: load outputs and go to DONE.
- Output computation on the normalized edge:
  - k = scale >>> ES (arithmetic shift); e = scale[ES-1:0].
  - frac = mant[MW-3 -: N]; sticky |= OR(mant[MW-3-N:0]).
  - If k > N-2: seed=N-2, exp=0, frac=0, sticky=0 (maxpos).
  - If k < -(N-2): seed=-(N-2), exp=0, frac=0, sticky=0 (minpos). Never saturates to zero.
- State DONE: out_valid=1 and all outputs are held stable.
  - On out_ready at an edge, go to IDLE and drop out_valid.
  - in_ready stays 0 in SHIFT and DONE; there is no overlap between operands.
- Latency, counted in edges from the accept edge to out_valid high:
  - Zero operand: 1.
  - Otherwise: s+2, where s is the shift count. s is 1 for overflow; it is at most MW-2 for left shifts.
- After out_ready, the next accept is possible at the following edge (IDLE cycle).
- in_valid while not in IDLE is ignored; the upstream block must hold the operand until in_ready.

Test Plan:
- Basic split: mant=0x40000000, scale=25 -> seed=3, exp=3'b001, frac=0, sticky=0; out_valid 2 edges after accept.
- Overflow right-shift with sticky: mant=0x80000001, scale=0 -> scale 1, seed=0, exp=1, frac=0, sticky=1; out_valid after 3 edges.
- Long left normalization: mant=0x00000001, scale=0 -> 30 shifts, scale=-30, seed=-4, exp=3'b010, frac=0; out_valid after 32 edges. Repeat with rst_n low at edge 10: out_valid never rises, in_ready returns high after reset.
- Fraction extraction: mant=0x60000000, scale=-20 -> seed=-3, exp=3'b100, frac=16'h8000, sticky=0.
- Saturation: mant=0x40000000, scale=200 -> seed=14, exp=0, frac=0. Scale=-200 -> seed=-14, exp=0, frac=0.
- Zero and backpressure: mant=0, sign=1 -> out_zero=1, out_sign=1, seed/exp/frac=0, out_valid after 1 edge. Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE, next operand accepted one edge later.
